// File: rtl/fft4_frame_ctrl_pkg.sv
// Shared definitions for the 4-point DFT frame controller:
// FSM state encoding and the bin-index width.
package fft4_frame_ctrl_pkg;

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fft4_frame_ctrl_butterfly.sv
// Combinational 4-point DFT butterfly.
// Samples are sign-extended by two bits first, so no sum can overflow.
module fft4_butterfly #(
  parameter int N = 8
) (
  input  logic [N-1:0] f0,
  input  logic [N-1:0] f1,
  input  logic [N-1:0] f2,
  input  logic [N-1:0] f3,
  output logic [N+1:0] y0_re,
  output logic [N+1:0] y0_im,
  output logic [N+1:0] y1_re,
  output logic [N+1:0] y1_im,
  output logic [N+1:0] y2_re,
  output logic [N+1:0] y2_im,
  output logic [N+1:0] y3_re,
  output logic [N+1:0] y3_im
);

  logic        [N-1:0] f_arr [4];
  logic signed [N+1:0] e     [4];

  assign f_arr[0] = f0;
  assign f_arr[1] = f1;
  assign f_arr[2] = f2;
  assign f_arr[3] = f3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ext
      assign e[gi] = {{2{f_arr[gi][N-1]}}, f_arr[gi]};
    end
  endgenerate

  // Twiddles of a 4-point DFT are only +-1 and +-j, so every bin is adds/subtracts.
  assign y0_re = e[0] + e[1] + e[2] + e[3];
  assign y0_im = '0;
  assign y1_re = e[0] - e[2];
  assign y1_im = e[3] - e[1];
  assign y2_re = e[0] - e[1] + e[2] - e[3];
  assign y2_im = '0;
  assign y3_re = e[0] - e[2];
  assign y3_im = e[1] - e[3];

endmodule

// File: rtl/fft4_frame_ctrl.sv
// Frame sequencer around the 4-point butterfly: loads four samples over a
// valid/ready stream, latches the eight butterfly outputs, then streams the
// four complex bins out over a second valid/ready stream.
module fft4_frame_ctrl
  import fft4_frame_ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N+1:0]     out_re,
  output logic [N+1:0]     out_im,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  state_t state_reg, state_next;

  logic [IDX_W-1:0] cnt_reg;
  logic [N-1:0]     samp_reg   [4];
  logic [N+1:0]     res_re_reg [4];
  logic [N+1:0]     res_im_reg [4];
  logic [N+1:0]     bf_re      [4];
  logic [N+1:0]     bf_im      [4];

  logic [N+1:0]     out_re_reg, out_im_reg;
  logic [IDX_W-1:0] out_idx_reg, idx_next;
  logic             out_last_reg, out_valid_reg;
  logic [CNT_W-1:0] frame_cnt_reg;

  logic in_fire, out_fire, calc_now, frame_done;

  fft4_butterfly #(.N(N)) u_bfly (
    .f0    (samp_reg[0]),
    .f1    (samp_reg[1]),
    .f2    (samp_reg[2]),
    .f3    (samp_reg[3]),
    .y0_re (bf_re[0]),
    .y0_im (bf_im[0]),
    .y1_re (bf_re[1]),
    .y1_im (bf_im[1]),
    .y2_re (bf_re[2]),
    .y2_im (bf_im[2]),
    .y3_re (bf_re[3]),
    .y3_im (bf_im[3])
  );

  assign calc_now   = (state_reg == CALC);
  assign idx_next   = out_idx_reg + 2'd1;
  assign frame_done = out_fire && (out_idx_reg == 2'd3);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= LOAD;
    else        state_reg <= state_next;
  end

  // Next-state decode plus handshake/busy outputs derived from the current state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    in_fire    = 1'b0;
    out_fire   = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        busy     = (cnt_reg != '0);
        if (in_fire && cnt_reg == 2'd3) state_next = CALC;
      end
      CALC: begin
        busy       = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        busy     = 1'b1;
        out_fire = out_valid_reg && out_ready;
        if (out_fire && out_idx_reg == 2'd3) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Sample buffer: write at the running count; the 2-bit count wraps to 0 after the 4th sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      for (int i = 0; i < 4; i++) samp_reg[i] <= '0;
    end else if (in_fire) begin
      samp_reg[cnt_reg] <= in_data;
      cnt_reg           <= cnt_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_res
      // Capture bin gi from the butterfly during the single CALC cycle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_re_reg[gi] <= '0;
          res_im_reg[gi] <= '0;
        end else if (calc_now) begin
          res_re_reg[gi] <= bf_re[gi];
          res_im_reg[gi] <= bf_im[gi];
        end
      end
    end
  endgenerate

  // Output bin registers; bin 0 comes straight from the butterfly so OUT starts valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_last_reg  <= 1'b0;
      out_re_reg    <= '0;
      out_im_reg    <= '0;
    end else if (calc_now) begin
      out_valid_reg <= 1'b1;
      out_idx_reg   <= '0;
      out_last_reg  <= 1'b0;
      out_re_reg    <= bf_re[0];
      out_im_reg    <= bf_im[0];
    end else if (out_fire) begin
      if (out_idx_reg == 2'd3) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end else begin
        out_idx_reg  <= idx_next;
        out_last_reg <= (idx_next == 2'd3);
        out_re_reg   <= res_re_reg[idx_next];
        out_im_reg   <= res_im_reg[idx_next];
      end
    end
  end

  // Completed-frame counter, bumped when bin 3 is taken; wraps silently.
  always_ff @(posedge clk) begin
    if (!rst_n)          frame_cnt_reg <= '0;
    else if (frame_done) frame_cnt_reg <= frame_cnt_reg + 1'b1;
  end

  assign out_re    = out_re_reg;
  assign out_im    = out_im_reg;
  assign out_idx   = out_idx_reg;
  assign out_last  = out_last_reg;
  assign out_valid = out_valid_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// Directed bench for fft4_frame_ctrl: hand-computed bins, latency, backpressure,
// gapped input, mid-frame reset, back-to-back frame period and counter wrap.
module tb_fft4_frame_ctrl;

  localparam int N     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N+1:0]     out_re, out_im;
  logic [1:0]       out_idx;
  logic             out_last, out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  fft4_frame_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int re;
    int im;
    int idx;
    int last;
    int fc;
    int cyc;
  } bin_t;

  bin_t bq[$];
  int   acc_cyc_q[$];
  int   lat_q[$];
  int   cyc = 0;
  int   last_acc = 0;
  int   rdy_mode = 0;
  int   pc = 0;

  // Monitor on the falling edge: records handshakes and checks hold/exclusivity rules.
  initial begin
    logic         prev_ov, prev_rdy, prev_last;
    logic [N+1:0] prev_re, prev_im;
    logic [1:0]   prev_idx;
    bin_t         b;
    prev_ov = 1'b0; prev_rdy = 1'b0; prev_last = 1'b0;
    prev_re = '0; prev_im = '0; prev_idx = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (prev_ov && !prev_rdy) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_re", $signed(out_re), $signed(prev_re));
          chk("hold_im", $signed(out_im), $signed(prev_im));
          chk("hold_idx", out_idx, prev_idx);
          chk("hold_last", out_last, prev_last);
        end
        if (out_valid) begin
          chk("inrdy_during_out", in_ready, 0);
          chk("busy_during_out", busy, 1);
        end
        if (out_valid && !prev_ov) lat_q.push_back(cyc - last_acc);
        if (in_valid && in_ready) begin
          acc_cyc_q.push_back(cyc);
          last_acc = cyc;
          $display("in  cyc=%0d data=%0d busy=%0b", cyc, $signed(in_data), busy);
        end
        if (out_valid && out_ready) begin
          b.re = $signed(out_re); b.im = $signed(out_im);
          b.idx = out_idx; b.last = out_last; b.fc = frame_cnt; b.cyc = cyc;
          bq.push_back(b);
          $display("out cyc=%0d idx=%0d re=%0d im=%0d last=%0b", cyc, b.idx, b.re, b.im, out_last);
        end
      end
      prev_ov   = rst_n ? out_valid : 1'b0;
      prev_rdy  = out_ready;
      prev_re   = out_re;
      prev_im   = out_im;
      prev_idx  = out_idx;
      prev_last = out_last;
    end
  end

  // Sink: ready always high, or the 1,0,0,1 pattern while rdy_mode is set.
  initial begin
    logic patt [4];
    patt[0] = 1'b1; patt[1] = 1'b0; patt[2] = 1'b0; patt[3] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        out_ready = patt[pc % 4];
        pc++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = v[N-1:0];
    while (!in_ready && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input int exp_busy);
    repeat (n) begin
      chk("busy_gap", busy, exp_busy);
      step();
    end
  endtask

  task automatic get_frame(input string tag,
                           input int r0, input int i0, input int r1, input int i1,
                           input int r2, input int i2, input int r3, input int i3,
                           output int fc3);
    int   er [4];
    int   ei [4];
    int   k;
    bin_t b;
    er[0] = r0; er[1] = r1; er[2] = r2; er[3] = r3;
    ei[0] = i0; ei[1] = i1; ei[2] = i2; ei[3] = i3;
    fc3 = -1;
    k = 0;
    while (bq.size() < 4 && k < 300) begin
      step();
      k++;
    end
    if (bq.size() < 4) begin
      chk({tag, "_timeout"}, bq.size(), 4);
      return;
    end
    for (int i = 0; i < 4; i++) begin
      b = bq.pop_front();
      chk($sformatf("%s_re%0d", tag, i), b.re, er[i]);
      chk($sformatf("%s_im%0d", tag, i), b.im, ei[i]);
      chk($sformatf("%s_idx%0d", tag, i), b.idx, i);
      chk($sformatf("%s_last%0d", tag, i), b.last, (i == 3) ? 1 : 0);
      if (i == 3) fc3 = b.fc;
    end
    if (lat_q.size() > 0) chk({tag, "_latency"}, lat_q.pop_front(), 2);
    else                  chk({tag, "_latency_missing"}, 0, 1);
  endtask

  initial begin
    int fc3, nb, nl;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_re", $signed(out_re), 0);
    chk("rst_out_im", $signed(out_im), 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    // Frame 1,2,1,0.
    send(1); send(2); send(1); send(0);
    get_frame("f1", 4, 0, 0, -2, 0, 0, 0, 2, fc3);
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_in_ready_after", in_ready, 1);
    chk("f1_busy_after", busy, 0);

    // All -128: full-scale negative.
    repeat (4) send(-128);
    get_frame("fneg", -512, 0, 0, 0, 0, 0, 0, 0, fc3);
    chk("fneg_frame_cnt", frame_cnt, 2);

    // Alternating extremes.
    send(127); send(-128); send(127); send(-128);
    get_frame("falt", -2, 0, 0, 0, 510, 0, 0, 0, fc3);
    chk("falt_frame_cnt", frame_cnt, 3);

    // Backpressure 1,0,0,1,...; frame counter wraps 3 -> 0 here.
    pc = 0;
    rdy_mode = 1;
    send(10); send(-20); send(30); send(-40);
    get_frame("fbp", -20, 0, -20, -20, 100, 0, -20, 20, fc3);
    rdy_mode = 0;
    chk("fbp_frame_cnt_wrap", frame_cnt, 0);
    chk("fbp_in_ready_after", in_ready, 1);

    // Gapped input: accepts on cycles 0,3,4,9.
    send(5);
    idle(2, 1);
    send(-7);
    send(2);
    idle(4, 1);
    send(9);
    get_frame("fgap", 9, 0, 3, 16, 5, 0, 3, -16, fc3);
    chk("fgap_frame_cnt", frame_cnt, 1);
    chk("fgap_busy_after", busy, 0);

    // Reset after two samples: partial frame discarded.
    send(3); send(4);
    nb = bq.size();
    nl = lat_q.size();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (6) begin
      chk("rst_mid_no_valid", out_valid, 0);
      step();
    end
    chk("rst_mid_no_bins", bq.size(), nb);
    chk("rst_mid_no_rise", lat_q.size(), nl);
    chk("rst_mid_frame_cnt", frame_cnt, 0);
    chk("rst_mid_busy", busy, 0);
    send(3); send(0); send(-3); send(0);
    get_frame("fclean", 0, 0, 6, 0, 0, 0, 6, 0, fc3);
    chk("fclean_frame_cnt", frame_cnt, 1);

    // Back-to-back frames with in_valid and out_ready held high.
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    acc_cyc_q.delete();
    for (int f = 1; f <= 4; f++) begin
      send(f); send(0); send(0); send(0);
    end
    for (int f = 1; f <= 4; f++) begin
      get_frame($sformatf("fb2b%0d", f), f, 0, f, 0, f, 0, f, 0, fc3);
      chk($sformatf("fb2b%0d_cnt_at_last", f), fc3, (f - 1) % 4);
    end
    chk("fb2b_frame_cnt_wrap", frame_cnt, 0);
    if (acc_cyc_q.size() >= 16) begin
      for (int f = 1; f < 4; f++)
        chk($sformatf("fb2b_period%0d", f), acc_cyc_q[4*f] - acc_cyc_q[4*f-4], 9);
    end else begin
      chk("fb2b_accept_count", acc_cyc_q.size(), 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
